// File: rtl/winograd_tile_feeder_if.sv
// Pixel-in / tile-out link of the winograd F(2x2,3x3) tile feeder.
// master = feeder side, slave = pixel producer / tile consumer side.
interface winograd_tile_feeder_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0]    pix_in;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [16*DATA_W-1:0] tile_data;
  logic                 tile_valid;
  logic                 tile_ready;
  logic [7:0]           tile_row;
  logic [7:0]           tile_col;
  logic                 frame_done;

  modport master (
    input  pix_in, pix_valid, tile_ready,
    output pix_ready, tile_data, tile_valid, tile_row, tile_col, frame_done
  );

  modport slave (
    output pix_in, pix_valid, tile_ready,
    input  pix_ready, tile_data, tile_valid, tile_row, tile_col, frame_done
  );
endinterface

// File: rtl/winograd_tile_feeder.sv
// Buffers a raster pixel stream in a 4-row line store and emits overlapping
// 4x4 tiles at stride 2 for a winograd F(2x2,3x3) engine.
module winograd_tile_feeder #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  winograd_tile_feeder_if.master bus
);
  localparam int NTX = (IMG_W - 2) / 2;
  localparam int NTY = (IMG_H - 2) / 2;
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);

  if ((IMG_W % 2) != 0 || IMG_W < 4) begin : g_bad_w
    $error("winograd_tile_feeder: IMG_W must be even and >= 4");
  end
  if ((IMG_H % 2) != 0 || IMG_H < 4) begin : g_bad_h
    $error("winograd_tile_feeder: IMG_H must be even and >= 4");
  end

  typedef enum logic [1:0] {FILL, EMIT, DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [7:0]           band_q, band_d;
  logic [7:0]           tcol_q, tcol_d;
  logic                 pix_ready_q;
  logic [16*DATA_W-1:0] tile_q, tile_d;
  logic [DATA_W-1:0]    buf_q [4][IMG_W];
  logic [DATA_W-1:0]    buf_d [4][IMG_W];
  logic                 pix_acc, tile_acc, load_tile;
  logic [7:0]           sel_tc;

  assign pix_acc  = (state_q == FILL) && pix_ready_q && bus.pix_valid;
  assign tile_acc = (state_q == EMIT) && bus.tile_ready;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    band_d    = band_q;
    tcol_d    = tcol_q;
    load_tile = 1'b0;
    sel_tc    = '0;
    case (state_q)
      FILL: begin
        if (pix_acc) begin
          if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            // Every odd row from 3 upward completes a band (3, 5, 7, ...).
            if (row_q[0] && row_q != RW'(1)) begin
              state_d   = EMIT;
              load_tile = 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      EMIT: begin
        if (tile_acc) begin
          if (tcol_q == 8'(NTX - 1)) begin
            tcol_d = '0;
            if (band_q == 8'(NTY - 1)) begin
              band_d  = '0;
              row_d   = '0;
              col_d   = '0;
              state_d = DONE;
            end else begin
              band_d  = band_q + 8'd1;
              state_d = FILL;
            end
          end else begin
            tcol_d    = tcol_q + 8'd1;
            sel_tc    = tcol_q + 8'd1;
            load_tile = 1'b1;
          end
        end
      end
      DONE:    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Tile is gathered from the post-write view so the pixel completing a band
  // is already visible when the first tile of that band is loaded.
  always_comb begin
    buf_d = buf_q;
    if (pix_acc) buf_d[row_q[1:0]][col_q] = bus.pix_in;
  end

  always_comb begin
    tile_d = tile_q;
    if (load_tile) begin
      for (int unsigned r = 0; r < 4; r++) begin
        for (int unsigned c = 0; c < 4; c++) begin
          tile_d[(r*4+c)*DATA_W +: DATA_W] =
            buf_d[2'({band_q[0], 1'b0} + r)][CW'(2*sel_tc + c)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      col_q       <= '0;
      row_q       <= '0;
      band_q      <= '0;
      tcol_q      <= '0;
      pix_ready_q <= 1'b0;
      tile_q      <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      band_q      <= band_d;
      tcol_q      <= tcol_d;
      pix_ready_q <= (state_d == FILL);
      tile_q      <= tile_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign bus.pix_ready  = pix_ready_q;
  assign bus.tile_valid = (state_q == EMIT);
  assign bus.frame_done = (state_q == DONE);
  assign bus.tile_data  = tile_q;
  assign bus.tile_row   = band_q;
  assign bus.tile_col   = tcol_q;
endmodule

// File: tb/tb_winograd_tile_feeder.sv
// Directed bench for winograd_tile_feeder on an 8x8 map with 8-bit pixels.
module tb_winograd_tile_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  winograd_tile_feeder_if #(.DATA_W(8)) bus ();

  winograd_tile_feeder #(.DATA_W(8), .IMG_W(8), .IMG_H(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int tmo = 0;
  int fd_cnt = 0;
  int emit_rdy = 0;
  int n_got = 0;
  logic [127:0] got_data [18];
  logic [7:0]   got_row  [18];
  logic [7:0]   got_col  [18];

  always @(negedge clk) begin
    if (bus.frame_done) fd_cnt++;
    if (bus.tile_valid && bus.pix_ready) emit_rdy++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pixv(input int kind, input int y, input int x);
    case (kind)
      0:       return 8'(8*y + x + 1);
      1:       return 8'(8*y + x + 101);
      default: return 8'(255 - (8*y + x));
    endcase
  endfunction

  function automatic logic [127:0] exp_tile(input int kind, input int i, input int j);
    logic [127:0] t;
    t = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[(r*4+c)*8 +: 8] = pixv(kind, 2*i + r, 2*j + c);
    return t;
  endfunction

  task automatic send_px(input logic [7:0] v, output bit ok);
    int k;
    k = 0;
    ok = 1'b0;
    bus.pix_in = v;
    bus.pix_valid = 1'b1;
    while (!ok && k < 200) begin
      if (bus.pix_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic get_tile(output bit ok);
    int k;
    k = 0;
    ok = 1'b0;
    while (!ok && k < 200) begin
      if (bus.tile_valid && bus.tile_ready) begin
        if (n_got < 18) begin
          got_data[n_got] = bus.tile_data;
          got_row[n_got]  = bus.tile_row;
          got_col[n_got]  = bus.tile_col;
        end
        n_got++;
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_reset();
    bus.pix_valid = 1'b0;
    bus.tile_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Streams one frame band by band and drains each band's tiles with tile_ready=1.
  task automatic run_frame(input int kind, input bit hold_pix);
    bit ok;
    bus.tile_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int y = (b == 0) ? 0 : 2*b + 2; y <= 2*b + 3; y++)
        for (int x = 0; x < 8; x++) begin
          send_px(pixv(kind, y, x), ok);
          if (!ok) tmo++;
        end
      if (hold_pix && b < 2) bus.pix_in = pixv(kind, 2*b + 4, 0);
      else bus.pix_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
        get_tile(ok);
        if (!ok) tmo++;
      end
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pix_valid = 1'b0;
    bus.tile_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.pix_ready !== 1'b0) begin n_err++; $display("FAIL rst_pix_ready got=%b exp=0", bus.pix_ready); end
    n_cmp++; if (bus.tile_valid !== 1'b0) begin n_err++; $display("FAIL rst_tile_valid got=%b exp=0", bus.tile_valid); end
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done got=%b exp=0", bus.frame_done); end
    n_cmp++; if (bus.tile_row !== 8'd0) begin n_err++; $display("FAIL rst_tile_row got=%0d exp=0", bus.tile_row); end
    n_cmp++; if (bus.tile_col !== 8'd0) begin n_err++; $display("FAIL rst_tile_col got=%0d exp=0", bus.tile_col); end
    n_cmp++; if (bus.tile_data !== 128'd0) begin n_err++; $display("FAIL rst_tile_data got=%h exp=0", bus.tile_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_tile();
    bit ok;
    do_reset();
    bus.tile_ready = 1'b1;
    for (int p = 0; p < 32; p++) begin
      send_px(pixv(0, p / 8, p % 8), ok);
      if (!ok) tmo++;
    end
    bus.pix_valid = 1'b0;
    n_cmp++; if (bus.tile_valid !== 1'b1) begin n_err++; $display("FAIL first_valid got=%b exp=1", bus.tile_valid); end
    n_cmp++; if (bus.tile_row !== 8'd0 || bus.tile_col !== 8'd0) begin n_err++; $display("FAIL first_rowcol got=%0d,%0d exp=0,0", bus.tile_row, bus.tile_col); end
    n_cmp++; if (bus.tile_data[0*8 +: 8] !== 8'd1) begin n_err++; $display("FAIL first_e00 got=%0d exp=1", bus.tile_data[0 +: 8]); end
    n_cmp++; if (bus.tile_data[3*8 +: 8] !== 8'd4) begin n_err++; $display("FAIL first_e03 got=%0d exp=4", bus.tile_data[24 +: 8]); end
    n_cmp++; if (bus.tile_data[4*8 +: 8] !== 8'd9) begin n_err++; $display("FAIL first_e10 got=%0d exp=9", bus.tile_data[32 +: 8]); end
    n_cmp++; if (bus.tile_data[15*8 +: 8] !== 8'd28) begin n_err++; $display("FAIL first_e33 got=%0d exp=28", bus.tile_data[120 +: 8]); end
    n_cmp++; if (bus.pix_ready !== 1'b0) begin n_err++; $display("FAIL first_pix_ready got=%b exp=0", bus.pix_ready); end
    n_cmp++; if (tmo !== 0) begin n_err++; $display("FAIL first_timeout got=%0d exp=0", tmo); end
  endtask

  task automatic test_full_frame();
    do_reset();
    n_got = 0;
    fd_cnt = 0;
    tmo = 0;
    run_frame(0, 1'b0);
    n_cmp++; if (bus.frame_done !== 1'b1) begin n_err++; $display("FAIL frame_done_pulse got=%b exp=1", bus.frame_done); end
    @(negedge clk);
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL frame_done_width got=%b exp=0", bus.frame_done); end
    @(negedge clk);
    n_cmp++; if (fd_cnt !== 1) begin n_err++; $display("FAIL frame_done_count got=%0d exp=1", fd_cnt); end
    n_cmp++; if (n_got !== 9) begin n_err++; $display("FAIL frame_tiles got=%0d exp=9", n_got); end
    n_cmp++; if (tmo !== 0) begin n_err++; $display("FAIL frame_timeout got=%0d exp=0", tmo); end
    for (int t = 0; t < 9; t++) begin
      n_cmp++;
      if (got_row[t] !== 8'(t / 3) || got_col[t] !== 8'(t % 3) || got_data[t] !== exp_tile(0, t / 3, t % 3)) begin
        n_err++;
        $display("FAIL frame_tile%0d got=(%0d,%0d) %h exp=(%0d,%0d) %h", t, got_row[t], got_col[t], got_data[t], t / 3, t % 3, exp_tile(0, t / 3, t % 3));
      end
    end
    n_cmp++; if (got_data[8][0 +: 8] !== 8'd37) begin n_err++; $display("FAIL t22_e00 got=%0d exp=37", got_data[8][0 +: 8]); end
    n_cmp++; if (got_data[8][120 +: 8] !== 8'd64) begin n_err++; $display("FAIL t22_e33 got=%0d exp=64", got_data[8][120 +: 8]); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    n_got = 0;
    tmo = 0;
    for (int p = 0; p < 32; p++) begin
      send_px(pixv(0, p / 8, p % 8), ok);
      if (!ok) tmo++;
    end
    bus.pix_valid = 1'b0;
    bus.tile_ready = 1'b1;
    get_tile(ok);
    if (!ok) tmo++;
    bus.tile_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (bus.tile_valid !== 1'b1 || bus.tile_row !== 8'd0 || bus.tile_col !== 8'd1 || bus.tile_data !== exp_tile(0, 0, 1)) begin
        n_err++;
        $display("FAIL stall_cyc%0d got=v%b (%0d,%0d) %h exp=v1 (0,1) %h", k, bus.tile_valid, bus.tile_row, bus.tile_col, bus.tile_data, exp_tile(0, 0, 1));
      end
      @(negedge clk);
    end
    bus.tile_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.tile_col !== 8'd2 || bus.tile_data !== exp_tile(0, 0, 2)) begin n_err++; $display("FAIL stall_release got=col%0d %h exp=col2 %h", bus.tile_col, bus.tile_data, exp_tile(0, 0, 2)); end
    n_cmp++; if (tmo !== 0) begin n_err++; $display("FAIL stall_timeout got=%0d exp=0", tmo); end
    bus.tile_ready = 1'b0;
  endtask

  task automatic test_pix_during_emit();
    do_reset();
    n_got = 0;
    tmo = 0;
    emit_rdy = 0;
    run_frame(0, 1'b1);
    @(negedge clk);
    n_cmp++; if (emit_rdy !== 0) begin n_err++; $display("FAIL emit_pix_ready got=%0d exp=0", emit_rdy); end
    n_cmp++; if (n_got !== 9) begin n_err++; $display("FAIL emit_tiles got=%0d exp=9", n_got); end
    for (int j = 0; j < 3; j++) begin
      n_cmp++;
      if (got_data[3 + j] !== exp_tile(0, 1, j)) begin n_err++; $display("FAIL band1_tile%0d got=%h exp=%h", j, got_data[3 + j], exp_tile(0, 1, j)); end
    end
    n_cmp++; if (got_data[3][0 +: 8] !== 8'd17) begin n_err++; $display("FAIL band1_e00 got=%0d exp=17", got_data[3][0 +: 8]); end
    n_cmp++; if (got_data[8] !== exp_tile(0, 2, 2)) begin n_err++; $display("FAIL emit_last got=%h exp=%h", got_data[8], exp_tile(0, 2, 2)); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    tmo = 0;
    for (int p = 0; p < 20; p++) begin
      send_px(pixv(0, p / 8, p % 8), ok);
      if (!ok) tmo++;
    end
    bus.pix_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.pix_ready !== 1'b0 || bus.tile_valid !== 1'b0 || bus.frame_done !== 1'b0) begin n_err++; $display("FAIL mrst_flags got=%b%b%b exp=000", bus.pix_ready, bus.tile_valid, bus.frame_done); end
    n_cmp++; if (bus.tile_row !== 8'd0 || bus.tile_col !== 8'd0) begin n_err++; $display("FAIL mrst_rowcol got=%0d,%0d exp=0,0", bus.tile_row, bus.tile_col); end
    n_cmp++; if (bus.tile_data !== 128'd0) begin n_err++; $display("FAIL mrst_data got=%h exp=0", bus.tile_data); end
    rst_n = 1'b1;
    @(negedge clk);
    n_got = 0;
    run_frame(1, 1'b0);
    n_cmp++; if (n_got !== 9) begin n_err++; $display("FAIL mrst_tiles got=%0d exp=9", n_got); end
    n_cmp++; if (got_data[0][0 +: 8] !== 8'd101) begin n_err++; $display("FAIL mrst_e00 got=%0d exp=101", got_data[0][0 +: 8]); end
    for (int t = 0; t < 9; t++) begin
      n_cmp++;
      if (got_data[t] !== exp_tile(1, t / 3, t % 3)) begin n_err++; $display("FAIL mrst_tile%0d got=%h exp=%h", t, got_data[t], exp_tile(1, t / 3, t % 3)); end
    end
    n_cmp++; if (tmo !== 0) begin n_err++; $display("FAIL mrst_timeout got=%0d exp=0", tmo); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    n_got = 0;
    tmo = 0;
    fd_cnt = 0;
    run_frame(0, 1'b0);
    run_frame(2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (n_got !== 18) begin n_err++; $display("FAIL b2b_tiles got=%0d exp=18", n_got); end
    n_cmp++; if (fd_cnt !== 2) begin n_err++; $display("FAIL b2b_frame_done got=%0d exp=2", fd_cnt); end
    n_cmp++; if (got_data[9][0 +: 8] !== 8'd255) begin n_err++; $display("FAIL b2b_e00 got=%0d exp=255", got_data[9][0 +: 8]); end
    for (int t = 0; t < 9; t++) begin
      n_cmp++;
      if (got_row[9 + t] !== 8'(t / 3) || got_col[9 + t] !== 8'(t % 3) || got_data[9 + t] !== exp_tile(2, t / 3, t % 3)) begin
        n_err++;
        $display("FAIL b2b_tile%0d got=(%0d,%0d) %h exp=(%0d,%0d) %h", t, got_row[9 + t], got_col[9 + t], got_data[9 + t], t / 3, t % 3, exp_tile(2, t / 3, t % 3));
      end
    end
    n_cmp++; if (tmo !== 0) begin n_err++; $display("FAIL b2b_timeout got=%0d exp=0", tmo); end
  endtask

  initial begin
    bus.pix_in = '0;
    bus.pix_valid = 1'b0;
    bus.tile_ready = 1'b0;
    test_reset();
    test_first_tile();
    test_full_frame();
    test_backpressure();
    test_pix_during_emit();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
